// File: rtl/pipe_control_unit.sv
// ID-stage decoder with a registered ID/EX control word.
// Handles load-use stalls, the multi-cycle mult hold and branch/jump flush.
module pipe_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int REG_ADDR_W  = 5,
    parameter int MULT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic                  mult_busy,
    output logic                  ex_valid,
    output logic                  ex_alusrc,
    output logic                  ex_memwrite,
    output logic                  ex_memread,
    output logic                  ex_memtoreg,
    output logic                  ex_regwrite,
    output logic                  ex_branch,
    output logic                  ex_jtopc,
    output logic                  ex_illegal,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_dst
);

    typedef struct packed {
        logic                  valid;
        logic                  alusrc;
        logic                  memwrite;
        logic                  memread;
        logic                  memtoreg;
        logic                  regwrite;
        logic                  branch;
        logic                  jtopc;
        logic                  illegal;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] dst;
    } ctl_t;

    typedef enum logic {RUN = 1'b0, MHOLD = 1'b1} mode_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;

    localparam logic       HOLD_EN = (MULT_CYCLES > 1) ? 1'b1 : 1'b0;
    localparam logic [3:0] MC_LOAD = 4'(MULT_CYCLES - 1);

    ctl_t       ex_r;
    ctl_t       ex_nxt_s;
    ctl_t       dec_s;
    logic [3:0] mcnt_r;
    logic [3:0] mcnt_nxt_s;
    logic       is_mult_s;
    logic       bad_s;
    logic       reads_rs_s;
    logic       reads_rt_s;
    logic       lu_s;
    mode_t      mode_s;

    function automatic logic [ALUOP_W-1:0] alu_code(input logic [3:0] code);
        return ALUOP_W'(code);
    endfunction

    // Instruction decode of the ID-stage fields into a control word.
    always_comb begin
        dec_s     = '0;
        is_mult_s = 1'b0;
        bad_s     = 1'b0;
        if (id_valid) begin
            dec_s.valid = 1'b1;
            case (opcode)
                OP_R: begin
                    dec_s.regwrite = 1'b1;
                    dec_s.dst      = rd;
                    case (funct)
                        F_ADD:   dec_s.aluop = alu_code(4'b0010);
                        F_SUB:   dec_s.aluop = alu_code(4'b0110);
                        F_AND:   dec_s.aluop = alu_code(4'b0000);
                        F_OR:    dec_s.aluop = alu_code(4'b0001);
                        F_SLT:   dec_s.aluop = alu_code(4'b0111);
                        F_XOR:   dec_s.aluop = alu_code(4'b1101);
                        F_NOR:   dec_s.aluop = alu_code(4'b1100);
                        F_MULT: begin
                            dec_s.aluop = alu_code(4'b1000);
                            is_mult_s   = 1'b1;
                        end
                        default: bad_s = 1'b1;
                    endcase
                end
                OP_LW: begin
                    dec_s.alusrc   = 1'b1;
                    dec_s.memread  = 1'b1;
                    dec_s.memtoreg = 1'b1;
                    dec_s.regwrite = 1'b1;
                    dec_s.dst      = rt;
                    dec_s.aluop    = alu_code(4'b0010);
                end
                OP_SW: begin
                    dec_s.alusrc   = 1'b1;
                    dec_s.memwrite = 1'b1;
                    dec_s.aluop    = alu_code(4'b0010);
                end
                OP_BEQ: begin
                    dec_s.branch = 1'b1;
                    dec_s.aluop  = alu_code(4'b0110);
                end
                OP_J: begin
                    dec_s.jtopc = 1'b1;
                    dec_s.aluop = alu_code(4'b1111);
                end
                default: bad_s = 1'b1;
            endcase
            // Illegal instructions travel as valid but side-effect free.
            if (bad_s) begin
                dec_s         = '0;
                dec_s.valid   = 1'b1;
                dec_s.illegal = 1'b1;
                is_mult_s     = 1'b0;
            end else begin
                dec_s.illegal = 1'b0;
            end
        end else begin
            dec_s = '0;
        end
    end

    // Load-use hazard detection against the load currently in EX.
    always_comb begin
        reads_rs_s = (opcode != OP_J);
        reads_rt_s = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
        lu_s = id_valid && ex_r.valid && ex_r.memread && (ex_r.dst != '0) &&
               (((ex_r.dst == rs) && reads_rs_s) || ((ex_r.dst == rt) && reads_rt_s));
    end

    // Priority arbitration: flush, multiply hold, load-use bubble, normal advance.
    always_comb begin
        mode_s     = (mcnt_r != 4'd0) ? MHOLD : RUN;
        ex_nxt_s   = ex_r;
        mcnt_nxt_s = mcnt_r;
        stall      = 1'b0;
        if (ex_flush) begin
            ex_nxt_s   = '0;
            mcnt_nxt_s = 4'd0;
        end else if (mode_s == MHOLD) begin
            stall      = 1'b1;
            mcnt_nxt_s = mcnt_r - 4'd1;
        end else if (lu_s) begin
            stall    = 1'b1;
            ex_nxt_s = '0;
        end else begin
            ex_nxt_s = dec_s;
            if (is_mult_s && HOLD_EN) begin
                mcnt_nxt_s = MC_LOAD;
            end else begin
                mcnt_nxt_s = 4'd0;
            end
        end
    end

    // ID/EX control register and multiply hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r   <= '0;
            mcnt_r <= 4'd0;
        end else begin
            ex_r   <= ex_nxt_s;
            mcnt_r <= mcnt_nxt_s;
        end
    end

    assign mult_busy   = (mcnt_r != 4'd0);
    assign ex_valid    = ex_r.valid;
    assign ex_alusrc   = ex_r.alusrc;
    assign ex_memwrite = ex_r.memwrite;
    assign ex_memread  = ex_r.memread;
    assign ex_memtoreg = ex_r.memtoreg;
    assign ex_regwrite = ex_r.regwrite;
    assign ex_branch   = ex_r.branch;
    assign ex_jtopc    = ex_r.jtopc;
    assign ex_illegal  = ex_r.illegal;
    assign ex_aluop    = ex_r.aluop;
    assign ex_dst      = ex_r.dst;

endmodule
